// File: rtl/sha256d_nonce_scan.sv
// Nonce-scan controller for a double SHA-256 core: serves the block header,
// steps the nonce, and compares each digest against a 256-bit target.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   wr_en/addr/data      host header writes (words 0..18, ignored while busy)
//   target               256-bit numeric difficulty target
//   nonce_start/end      inclusive scan range, captured on go
//   go, abort            start scan (IDLE only) / stop at next hash boundary
//   hash_start           one-cycle start strobe to the hasher
//   bus_rq/addr/data/rdy hasher word-request bus, combinational, zero wait
//   hash_in, hash_done   digest (big-endian bytes) and completion strobe
//   busy, found          scan in progress / winner seen this scan
//   exhausted            range finished without stopping on a win
//   found_nonce          last winning nonce
//   cur_nonce            nonce currently being hashed
module sha256d_nonce_scan #(
    parameter bit STOP_ON_FOUND = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [4:0]   wr_addr,
    input  logic [31:0]  wr_data,
    input  logic [255:0] target,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_end,
    input  logic         go,
    input  logic         abort,
    output logic         hash_start,
    input  logic         bus_rq,
    input  logic [4:0]   bus_addr,
    output logic [31:0]  bus_data,
    output logic         bus_rdy,
    input  logic [255:0] hash_in,
    input  logic         hash_done,
    output logic         busy,
    output logic         found,
    output logic         exhausted,
    output logic [31:0]  found_nonce,
    output logic [31:0]  cur_nonce
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic           busy_q, busy_d;
    logic           found_q, found_d;
    logic           exh_q, exh_d;
    logic           abort_q, abort_d;
    logic [31:0]    fnonce_q, fnonce_d;
    logic [31:0]    cur_q, cur_d;
    logic [31:0]    end_q, end_d;
    logic [255:0]   digest_q, digest_d;
    logic [31:0]    hdr_q [0:18];

    logic [255:0]   hash_num;
    logic           win;
    logic [31:0]    nonce_le;

    // Header storage has no reset; the host reloads it per job.
    always_ff @(posedge clk) begin
        if (wr_en && !busy_q && (wr_addr < 5'd19)) begin
            hdr_q[wr_addr] <= wr_data;
        end
    end

    // The header nonce field is little-endian.
    assign nonce_le = {cur_q[7:0], cur_q[15:8], cur_q[23:16], cur_q[31:24]};

    always_comb begin
        bus_data = '0;
        if (bus_rq) begin
            if (bus_addr < 5'd19) begin
                bus_data = hdr_q[bus_addr];
            end else if (bus_addr == 5'd19) begin
                bus_data = nonce_le;
            end
        end
    end

    assign bus_rdy = bus_rq;

    // Digest byte 31 becomes the numeric MSB (Bitcoin hash ordering).
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            hash_num[8*i +: 8] = digest_q[8*(31-i) +: 8];
        end
    end

    assign win = (hash_num <= target);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            busy_q   <= 1'b0;
            found_q  <= 1'b0;
            exh_q    <= 1'b0;
            abort_q  <= 1'b0;
            fnonce_q <= '0;
            cur_q    <= '0;
            end_q    <= '0;
            digest_q <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            found_q  <= found_d;
            exh_q    <= exh_d;
            abort_q  <= abort_d;
            fnonce_q <= fnonce_d;
            cur_q    <= cur_d;
            end_q    <= end_d;
            digest_q <= digest_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        found_d  = found_q;
        exh_d    = exh_q;
        fnonce_d = fnonce_q;
        cur_d    = cur_q;
        end_d    = end_q;
        digest_d = digest_q;
        // The hasher cannot be interrupted, so abort is only remembered
        // here and acted on at the next CHECK.
        abort_d  = abort_q | (busy_q & abort);

        unique case (state_q)
            S_IDLE: begin
                if (go) begin
                    cur_d   = nonce_start;
                    end_d   = nonce_end;
                    found_d = 1'b0;
                    exh_d   = 1'b0;
                    busy_d  = 1'b1;
                    abort_d = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (hash_done) begin
                    digest_d = hash_in;
                    state_d  = S_CHECK;
                end
            end
            S_CHECK: begin
                if (win) begin
                    found_d  = 1'b1;
                    fnonce_d = cur_q;
                end
                if (win && STOP_ON_FOUND) begin
                    state_d = S_DONE;
                end else if (abort_q) begin
                    state_d = S_DONE;
                end else if (cur_q == end_q) begin
                    exh_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cur_d   = cur_q + 32'd1;
                    state_d = S_START;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                abort_d = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign hash_start  = (state_q == S_START);
    assign busy        = busy_q;
    assign found       = found_q;
    assign exhausted   = exh_q;
    assign found_nonce = fnonce_q;
    assign cur_nonce   = cur_q;

endmodule
